// File: rtl/branch_predict_unit_pkg.sv
// Shared constants for branch resolution and prediction: opcodes,
// 2-bit counter encodings and the branch-opcode test used by decode.
package branch_predict_unit_pkg;

   localparam logic [4:0] OP_BEQZ = 5'b01100;
   localparam logic [4:0] OP_BNEZ = 5'b01101;
   localparam logic [4:0] OP_BLTZ = 5'b01110;
   localparam logic [4:0] OP_BGEZ = 5'b01111;

   localparam logic [1:0] CTR_SNT = 2'b00;   // strongly not-taken
   localparam logic [1:0] CTR_WNT = 2'b01;   // weakly not-taken
   localparam logic [1:0] CTR_WT  = 2'b10;   // weakly taken
   localparam logic [1:0] CTR_ST  = 2'b11;   // strongly taken

   localparam logic [1:0] CTR_INIT_DEFAULT = CTR_WNT;

   // The four conditional branches occupy the contiguous block 011xx.
   function automatic logic is_branch(input logic [4:0] op);
      return (op[4:2] == 3'b011);
   endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-side prediction port and execute-side resolve port of the
// branch predictor, plus its statistics outputs.
interface branch_predict_unit_if #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 16,
   parameter int CNT_W  = 16
);
   logic [PC_W-1:0]   pred_pc;
   logic [4:0]        pred_op;
   logic              pred_taken;
   logic              res_valid;
   logic [4:0]        res_op;
   logic [PC_W-1:0]   res_pc;
   logic [DATA_W-1:0] res_rs;
   logic              res_pred_taken;
   logic              res_taken;
   logic              mispredict;
   logic [CNT_W-1:0]  br_cnt;
   logic [CNT_W-1:0]  mp_cnt;

   modport master (
      output pred_pc, pred_op, res_valid, res_op, res_pc, res_rs, res_pred_taken,
      input  pred_taken, res_taken, mispredict, br_cnt, mp_cnt
   );

   modport slave (
      input  pred_pc, pred_op, res_valid, res_op, res_pc, res_rs, res_pred_taken,
      output pred_taken, res_taken, mispredict, br_cnt, mp_cnt
   );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation from the full source operand.
module branch_cond_eval
   import branch_predict_unit_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [4:0]        op,
   input  logic [DATA_W-1:0] rs,
   output logic              is_br,
   output logic              taken
);

   // Direction from operand value; non-branches report not-taken.
   always_comb begin
      is_br = is_branch(op);
      case (op)
         OP_BEQZ: taken = (rs == '0);
         OP_BNEZ: taken = (rs != '0);
         OP_BLTZ: taken = rs[DATA_W-1];
         OP_BGEZ: taken = ~rs[DATA_W-1];
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: table of 2-bit saturating counters read at fetch,
// trained at resolve, with registered mispredict flag and statistics.
module branch_predict_unit
   import branch_predict_unit_pkg::*;
#(
   parameter int         DATA_W   = 16,
   parameter int         PC_W     = 16,
   parameter int         IDX_W    = 4,
   parameter int         CNT_W    = 16,
   parameter logic [1:0] CTR_INIT = CTR_INIT_DEFAULT
) (
   input logic                  clk,
   input logic                  rst_n,
   branch_predict_unit_if.slave bus
);

   localparam int DEPTH = 1 << IDX_W;

   logic [1:0]       ctr [DEPTH];
   logic [IDX_W-1:0] pred_idx;
   logic [IDX_W-1:0] res_idx;
   logic             res_br;
   logic             res_dir;
   logic             upd;
   logic             miss;
   logic [1:0]       cur_ctr;
   logic [1:0]       next_ctr;
   logic             res_taken_q;
   logic             mispredict_q;
   logic [CNT_W-1:0] br_q;
   logic [CNT_W-1:0] mp_q;
   logic             unused_pc;

   // Instructions are 16-bit, so pc[0] never selects an entry.
   assign pred_idx  = bus.pred_pc[IDX_W:1];
   assign res_idx   = bus.res_pc[IDX_W:1];
   assign unused_pc = ^{bus.pred_pc[PC_W-1:IDX_W+1], bus.pred_pc[0],
                        bus.res_pc[PC_W-1:IDX_W+1], bus.res_pc[0]};

   branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
      .op    (bus.res_op),
      .rs    (bus.res_rs),
      .is_br (res_br),
      .taken (res_dir)
   );

   assign upd  = bus.res_valid & res_br;
   assign miss = res_dir ^ bus.res_pred_taken;

   // Zero-latency prediction; reads the pre-update value on an index clash.
   assign bus.pred_taken = is_branch(bus.pred_op) & ctr[pred_idx][1];

   // Saturating step of the counter selected by the resolving branch.
   always_comb begin
      cur_ctr  = ctr[res_idx];
      next_ctr = cur_ctr;
      if (res_dir) begin
         if (cur_ctr != CTR_ST) next_ctr = cur_ctr + 2'd1;
      end else begin
         if (cur_ctr != CTR_SNT) next_ctr = cur_ctr - 2'd1;
      end
   end

   // Counter table: reset to CTR_INIT, trained by each resolved branch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ctr[i] <= CTR_INIT;
      end else if (upd) begin
         ctr[res_idx] <= next_ctr;
      end
   end

   // Registered resolve outputs and saturating statistics.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_taken_q  <= 1'b0;
         mispredict_q <= 1'b0;
         br_q         <= '0;
         mp_q         <= '0;
      end else begin
         res_taken_q  <= upd & res_dir;
         mispredict_q <= upd & miss;
         if (upd && br_q != '1) br_q <= br_q + 1'b1;
         if (upd && miss && mp_q != '1) mp_q <= mp_q + 1'b1;
      end
   end

   assign bus.res_taken  = res_taken_q;
   assign bus.mispredict = mispredict_q;
   assign bus.br_cnt     = br_q;
   assign bus.mp_cnt     = mp_q;

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction unit for the pipelined core. It evaluates BEQZ/BNEZ/BLTZ/BGEZ from a full-width source operand rather than precomputed flags, and keeps a table of 2-bit saturating counters that predicts branch direction at fetch. It flags mispredictions to the pipeline flush logic one cycle after resolution and keeps saturating branch and mispredict statistics.

## Interface
- DATA_W, 16, width of the branch source register operand
- PC_W, 16, program counter width
- IDX_W, 4, table index width; table depth is 2^IDX_W entries
- CNT_W, 16, width of the statistics counters
- CTR_INIT, 2'b01, counter value loaded into every table entry at reset
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- pred_pc  input  PC_W  PC of the instruction in fetch
- pred_op  input  5  opcode of the instruction in fetch
- pred_taken  output  1  predicted direction (combinational)
- res_valid  input  1  resolve port carries a valid instruction this cycle
- res_op  input  5  opcode of the instruction in execute
- res_pc  input  PC_W  PC of the instruction in execute
- res_rs  input  DATA_W  branch source operand (two's complement)
- res_pred_taken  input  1  prediction made for this instruction at fetch
- res_taken  output  1  registered actual branch direction
- mispredict  output  1  registered one-cycle flush request
- br_cnt  output  CNT_W  resolved branches, saturating
- mp_cnt  output  CNT_W  mispredicted branches, saturating

## Operation
- Branch opcodes: 01100 BEQZ (taken if rs==0), 01101 BNEZ (rs!=0), 01110 BLTZ (rs[DATA_W-1]==1), 01111 BGEZ (rs[DATA_W-1]==0). All other opcodes are non-branch.
- Table index = pc[IDX_W:1] (16-bit instructions, so pc[0] is ignored). This applies to both pred_pc and res_pc.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- pred_taken = table[idx(pred_pc)][1] when pred_op is a branch opcode; otherwise 0.
- On a clock edge with res_valid=1 and a branch res_op:
  - the counter at idx(res_pc) increments if the branch is taken, saturating at 11;
  - the counter decrements if not taken, saturating at 00;
  - res_taken <= actual direction;
  - mispredict <= (actual != res_pred_taken);
  - br_cnt increments; mp_cnt increments on a mispredict. Both saturate at all-ones.
- On a clock edge with res_valid=0, or with a non-branch res_op: no table or counter change; res_taken <= 0; mispredict <= 0.
- Reset (rst_n=0 at an edge): every table entry <= CTR_INIT; res_taken, mispredict, br_cnt and mp_cnt <= 0. Reset overrides a simultaneous resolve, and an in-flight resolve is discarded.

## Timing
- Prediction has zero latency: pred_taken is a combinational read of the table.
- Resolution has 1-cycle latency: mispredict and res_taken are valid the cycle after res_valid, and mispredict is high for exactly one cycle per mispredicted branch.
- Back-to-back resolves in consecutive cycles are each fully processed. There is no stall and no backpressure.
- When the fetch index and resolve index are the same in one cycle, pred_taken reflects the pre-update counter value (read-before-write, no bypass).
- The updated counter is visible to pred_taken from the cycle after the update edge.
- Statistics counters update on the same edge as the table.

## Structure
- Shared package/header holds:
  - the BEQZ/BNEZ/BLTZ/BGEZ opcode constants (common with decode);
  - the 2-bit counter encodings and the CTR_INIT default;
  - an is_branch(op) function.
- Natural sub-module: branch_cond_eval. It is combinational: it takes op and rs and outputs is_branch and taken.
- The table, its update logic, the output registers and the statistics counters stay in the top module.

## Test plan
- Reset with defaults → every entry reads 01; pred_taken=0 for a BEQZ at any PC; br_cnt=0, mp_cnt=0, mispredict=0.
- Resolve BEQZ at pc=0x0004 with rs=0 and res_pred_taken=0 twice in consecutive cycles → mispredict=1 both following cycles; entry 2 becomes 10 then 11; pred_taken=1 at pc=0x0004; mp_cnt=2.
- Resolve BLTZ with rs=0x8000 and BGEZ with rs=0x7FFF, both with pred=1 → res_taken=1 each, no mispredict; entry stays saturated at 11.
- Resolve BNEZ with rs=0 three times at one PC from 01 → entry 00 and held (saturates low); pred_taken=0.
- Same-cycle predict and resolve at pc=0x0010 with the entry at 01 and a taken branch → pred_taken=0 that cycle and 1 the next.
- res_valid=1 with op=00000 → no update, mispredict=0. Separately, assert rst_n=0 in the cycle after a mispredicting resolve → mispredict=0 and all entries back to 01.
